// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, drives one at a time into an external ALU, returns registered results
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_ready = FIFO not full
//   cmd_op, cmd_a, cmd_b          opcode and operands pushed into the FIFO
//   alu_a, alu_b, alu_sel         registered operands/opcode driven to the ALU
//   alu_out, alu_cout             combinational ALU result and carry
//   res_valid/res_ready           result handshake
//   res_data, res_carry,
//   res_zero, res_dbz             captured result and status flags
//   op_count                      number of results delivered (wraps)
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_carry,
  output logic        res_zero,
  output logic        res_dbz,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
  state_t r_state, w_next;
  logic [19:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic [7:0] r_a, r_b, r_data;
  logic [3:0] r_sel;
  logic r_carry, r_zero, r_dbz;
  logic [15:0] r_op_count;
  logic w_empty, w_push, w_pop, w_dbz;
  logic [7:0] w_data;
  logic [19:0] w_head;
  assign w_empty = r_count == '0;
  assign cmd_ready = r_count != L_FULL;
  assign w_push = cmd_valid & cmd_ready;
  assign w_head = r_mem[r_rptr];
  // Divide-by-zero is decided from the registered command, not from the ALU output.
  assign w_dbz = (r_sel == 4'b0011) && (r_b == 8'h00);
  assign w_data = w_dbz ? 8'hFF : alu_out;
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = !w_empty;
        w_next = w_empty ? S_IDLE : S_EXEC;
      end
      S_EXEC: w_next = S_DONE;
      S_DONE: begin
        w_pop = res_ready & !w_empty;
        w_next = !res_ready ? S_DONE : (w_empty ? S_IDLE : S_EXEC);
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {cmd_op, cmd_a, cmd_b};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  // Operand registers change only on a pop, so the ALU inputs stay frozen through EXEC.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sel <= '0;
      r_a <= '0;
      r_b <= '0;
      r_data <= '0;
      r_carry <= 1'b0;
      r_zero <= 1'b0;
      r_dbz <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_pop) {r_sel, r_a, r_b} <= w_head;
      if (r_state == S_EXEC) begin
        r_data <= w_data;
        r_carry <= (r_sel == 4'b0000) & alu_cout;
        r_zero <= w_data == 8'h00;
        r_dbz <= w_dbz;
      end
      if (r_state == S_DONE && res_ready) r_op_count <= r_op_count + 16'd1;
    end
  assign alu_a = r_a;
  assign alu_b = r_b;
  assign alu_sel = r_sel;
  assign res_valid = r_state == S_DONE;
  assign res_data = r_data;
  assign res_carry = r_carry;
  assign res_zero = r_zero;
  assign res_dbz = r_dbz;
  assign op_count = r_op_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural ALU and result model
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, alu_cout, res_valid, res_ready;
  logic res_carry, res_zero, res_dbz, noise;
  logic [3:0] cmd_op, alu_sel;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data;
  logic [15:0] op_count;
  typedef struct packed {
    logic [7:0] data;
    logic carry;
    logic zero;
    logic dbz;
  } exp_t;
  exp_t q[$];
  int dq[$];
  int cyc = 0, tests = 0, fails = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  alu_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_dbz(res_dbz),
    .op_count(op_count)
  );
  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 8'h00) ? 8'h00 : a / b;
      4'h4: return a << 1;
      4'h5: return a >> 1;
      4'h6: return {a[6:0], a[7]};
      4'h7: return {a[0], a[7:1]};
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a | b);
      4'hC: return ~(a & b);
      4'hD: return ~(a ^ b);
      4'hE: return (a > b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction
  logic [8:0] alu_sum;
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_cout = (alu_sel == 4'h0) ? alu_sum[8] : noise;
  function automatic exp_t model(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    exp_t e;
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    e.dbz = (op == 4'h3) && (b == 8'h00);
    e.data = e.dbz ? 8'hFF : alu_fn(a, b, op);
    e.carry = (op == 4'h0) ? s[8] : 1'b0;
    e.zero = e.data == 8'h00;
    return e;
  endfunction
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (res_valid) begin
        if (q.size() == 0) chk("spurious_result", 32'(res_valid), 32'd0);
        else begin
          e = q[0];
          chk("res_data", 32'(res_data), 32'(e.data));
          chk("res_carry", 32'(res_carry), 32'(e.carry));
          chk("res_zero", 32'(res_zero), 32'(e.zero));
          chk("res_dbz", 32'(res_dbz), 32'(e.dbz));
          chk("op_count", 32'(op_count), 32'(exp_cnt[15:0]));
          if (res_ready) begin
            void'(q.pop_front());
            exp_cnt++;
            dq.push_back(cyc);
          end
        end
      end
      if (cmd_valid && cmd_ready) q.push_back(model(cmd_op, cmd_a, cmd_b));
    end
  end
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    int n;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    for (n = 0; n < 200 && !cmd_ready; n++) tick(1);
    if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
    tick(1);
  endtask
  task automatic drain();
    for (int n = 0; n < 500 && q.size() != 0; n++) tick(1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int d0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    noise = 1'b1;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    #2;
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'({res_data, res_carry, res_zero, res_dbz}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick(2);
    rst = 1'b0;
    tick(1);
    res_ready = 1'b1;
    push(4'h0, 8'hF0, 8'h20);
    cmd_valid = 1'b0;
    chk("t1_lat_n1", 32'(res_valid), 32'd0);
    tick(1);
    chk("t1_lat_n2", 32'(res_valid), 32'd0);
    tick(1);
    chk("t1_lat_n3", 32'(res_valid), 32'd1);
    tick(1);
    chk("t1_data", 32'({res_data, res_carry, res_zero}), 32'({8'h10, 1'b1, 1'b0}));
    chk("t1_count", 32'(op_count), 32'd1);
    push(4'h3, 8'h40, 8'h00);
    cmd_valid = 1'b0;
    drain();
    tick(1);
    chk("t2_dbz", 32'({res_data, res_carry, res_dbz}), 32'({8'hFF, 1'b0, 1'b1}));
    noise = 1'b1;
    push(4'h1, 8'h33, 8'h33);
    cmd_valid = 1'b0;
    drain();
    tick(1);
    chk("t3_zero", 32'({res_data, res_carry, res_zero}), 32'({8'h00, 1'b0, 1'b1}));
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'(i + 9), 8'($urandom), 8'($urandom));
    cmd_op = 4'h8;
    tick(4);
    chk("t4_full_ready", 32'(cmd_ready), 32'd0);
    chk("t4_held_valid", 32'(res_valid), 32'd1);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    drain();
    tick(1);
    chk("t4_count", 32'(op_count), 32'd8);
    d0 = dq.size();
    for (int i = 0; i < 16; i++) push(4'(i), 8'($urandom), 8'($urandom));
    cmd_valid = 1'b0;
    drain();
    if (dq.size() >= d0 + 16) chk("t5_throughput", 32'(dq[d0 + 15] - dq[d0]), 32'd30);
    else chk("t5_results", 32'(dq.size() - d0), 32'd16);
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom);
      cmd_op = 4'($urandom);
      cmd_a = 8'($urandom);
      cmd_b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      res_ready = 1'($urandom);
      noise = 1'($urandom);
      tick(1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    drain();
    res_ready = 1'b0;
    push(4'h0, 8'h01, 8'h02);
    push(4'h8, 8'hFF, 8'h0F);
    push(4'h9, 8'h10, 8'h01);
    push(4'hA, 8'h55, 8'hAA);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick(1);
    chk("t6_in_exec", 32'(res_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(res_valid), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    chk("t6_rst_count", 32'(op_count), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("t6_no_stale", 32'(res_valid), 32'd0);
    chk("t6_count_after", 32'(op_count), 32'd0);
    push(4'h8, 8'h0F, 8'h3C);
    cmd_valid = 1'b0;
    drain();
    tick(1);
    chk("t6_recover", 32'({res_data, op_count}), 32'({8'h0C, 16'd1}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
